shifter_operand_pipe: RTL

//   Pipelined, parametrised operand-2 generator for the EXE stage. Produces the
//   ALU second operand and the shifter carry-out from Rm, Rs and the 12-bit

---
 rtl/arm_pkg.sv | 33 +++
 rtl/shifter_operand_pipe_if.sv | 32 +++
 rtl/barrel_shifter.sv | 82 ++++++++
 rtl/shifter_operand_pipe.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shift-type codes, amount classes and the amount classifier shared by the operand-2 pipeline.
// Pure declarations: no latency and no flow control of its own.
package arm_pkg;

  localparam int ARM_DATA_W = 32;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } sh_type_e;

  typedef enum logic [1:0] {
    AMT_ZERO,
    AMT_LT,
    AMT_EQ,
    AMT_GT
  } amt_cls_e;

  // ROR only cares about n mod w, so a multiple of w maps to EQ (value kept, carry = msb).
  function automatic amt_cls_e classify_amt(input sh_type_e sh, input int unsigned n,
                                            input int unsigned w);
    amt_cls_e cls;
    if (n == 0)             cls = AMT_ZERO;
    else if (sh == SH_ROR)  cls = ((n & (w - 1)) == 0) ? AMT_EQ : AMT_LT;
    else if (n < w)         cls = AMT_LT;
    else if (n == w)        cls = AMT_EQ;
    else                    cls = AMT_GT;
    return cls;
  endfunction

endpackage

// File: rtl/shifter_operand_pipe_if.sv
// Request/result bundle of the operand-2 pipeline: valid/ready in, valid/ready out, flush and tag.
// The master side drives requests and out_ready; the slave side is the pipeline.
interface shifter_operand_pipe_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 8
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [11:0]       shift_op;
  logic              imm;
  logic              mem_op;
  logic [DATA_W-1:0] val_rm;
  logic [DATA_W-1:0] val_rs;
  logic              c_in;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] val2;
  logic              shift_c;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output flush, in_valid, shift_op, imm, mem_op, val_rm, val_rs, c_in, in_tag, out_ready,
    input  in_ready, out_valid, val2, shift_c, out_tag
  );

  modport slave (
    input  flush, in_valid, shift_op, imm, mem_op, val_rm, val_rs, c_in, in_tag, out_ready,
    output in_ready, out_valid, val2, shift_c, out_tag
  );
endinterface

// File: rtl/barrel_shifter.sv
// Combinational ARM barrel shifter driven by a pre-decoded amount class; zero latency.
// r is only used for AMT_LT; ROR with AMT_ZERO is RRX through c_in.
module barrel_shifter
  import arm_pkg::*;
#(
  parameter int DATA_W = ARM_DATA_W,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] in_dat,
  input  logic [SH_W-1:0]   r,
  input  sh_type_e          sh_type,
  input  amt_cls_e          amt_cls,
  input  logic              c_in,
  output logic [DATA_W-1:0] out_dat,
  output logic              carry
);

  logic                msb;
  logic [SH_W-1:0]     r_m1;
  logic [SH_W-1:0]     r_neg;
  logic [2*DATA_W-1:0] rot_dbl;

  assign msb     = in_dat[DATA_W-1];
  assign r_m1    = r - SH_W'(1);
  assign r_neg   = '0 - r;
  assign rot_dbl = {in_dat, in_dat} >> r;

  always_comb begin
    out_dat = in_dat;
    carry   = c_in;
    case (amt_cls)
      AMT_ZERO: begin
        if (sh_type == SH_ROR) begin
          out_dat = {c_in, in_dat[DATA_W-1:1]};
          carry   = in_dat[0];
        end
      end
      AMT_LT: begin
        carry = in_dat[r_m1];
        case (sh_type)
          SH_LSL: begin
            out_dat = in_dat << r;
            carry   = in_dat[r_neg];
          end
          SH_LSR:  out_dat = in_dat >> r;
          SH_ASR:  out_dat = $unsigned($signed(in_dat) >>> r);
          default: out_dat = rot_dbl[DATA_W-1:0];
        endcase
      end
      AMT_EQ: begin
        case (sh_type)
          SH_LSL: begin
            out_dat = '0;
            carry   = in_dat[0];
          end
          SH_LSR: begin
            out_dat = '0;
            carry   = msb;
          end
          SH_ASR: begin
            out_dat = {DATA_W{msb}};
            carry   = msb;
          end
          default: carry = msb;
        endcase
      end
      default: begin
        // Beyond the width: ASR saturates to the sign, logical shifts drain to zero.
        if (sh_type == SH_ASR) begin
          out_dat = {DATA_W{msb}};
          carry   = msb;
        end else if (sh_type == SH_ROR) begin
          carry = msb;
        end else begin
          out_dat = '0;
          carry   = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: rtl/shifter_operand_pipe.sv
// EXE operand-2 generator: decode (mem / rotated imm / shifted Rm) then barrel shift, tag alongside.
// Latency PIPE_STAGES cycles at one result per cycle; stages hold under out_ready low, flush empties all.
module shifter_operand_pipe
  import arm_pkg::*;
#(
  parameter int DATA_W      = ARM_DATA_W,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shifter_operand_pipe_if.slave bus
);

  localparam int SH_W = $clog2(DATA_W);

  sh_type_e          s1_sh_d;
  amt_cls_e          s1_cls_d;
  logic [SH_W-1:0]   s1_r_d;
  logic [DATA_W-1:0] s1_opnd_d;
  logic [31:0]       amt_n;
  sh_type_e          sh_fld;
  logic [SH_W-1:0]   rot_imm;

  logic              in_rdy;
  logic              out_vld_q;
  logic [DATA_W-1:0] val2_q;
  logic              shift_c_q;
  logic [TAG_W-1:0]  tag_q;

  assign sh_fld  = sh_type_e'(bus.shift_op[6:5]);
  assign rot_imm = SH_W'({bus.shift_op[11:8], 1'b0});
  assign amt_n   = bus.shift_op[4] ? {24'd0, bus.val_rs[7:0]} : {27'd0, bus.shift_op[11:7]};

  // Every form is reduced to (operand, type, class, r); plain pass-through is LSL/ZERO.
  always_comb begin
    s1_sh_d   = SH_LSL;
    s1_cls_d  = AMT_ZERO;
    s1_r_d    = '0;
    s1_opnd_d = bus.val_rm;
    if (bus.mem_op) begin
      s1_opnd_d = {{(DATA_W-12){1'b0}}, bus.shift_op};
    end else if (bus.imm) begin
      s1_opnd_d = {{(DATA_W-8){1'b0}}, bus.shift_op[7:0]};
      if (rot_imm != '0) begin
        s1_sh_d  = SH_ROR;
        s1_cls_d = AMT_LT;
        s1_r_d   = rot_imm;
      end
    end else if (!bus.shift_op[4] && amt_n == 32'd0) begin
      s1_sh_d = sh_fld;
      case (sh_fld)
        SH_LSR, SH_ASR: s1_cls_d = AMT_EQ;
        default:        s1_cls_d = AMT_ZERO;
      endcase
    end else begin
      s1_cls_d = classify_amt(sh_fld, amt_n, DATA_W);
      s1_sh_d  = (s1_cls_d == AMT_ZERO) ? SH_LSL : sh_fld;
      s1_r_d   = amt_n[SH_W-1:0];
    end
  end

  generate
    if (PIPE_STAGES == 1) begin : g_one
      logic [DATA_W-1:0] bs_out;
      logic              bs_c;

      barrel_shifter #(.DATA_W(DATA_W), .SH_W(SH_W)) u_bs (
        .in_dat (s1_opnd_d),
        .r      (s1_r_d),
        .sh_type(s1_sh_d),
        .amt_cls(s1_cls_d),
        .c_in   (bus.c_in),
        .out_dat(bs_out),
        .carry  (bs_c)
      );

      assign in_rdy = !out_vld_q | bus.out_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_vld_q <= 1'b0;
          val2_q    <= '0;
          shift_c_q <= 1'b0;
          tag_q     <= '0;
        end else if (bus.flush) begin
          out_vld_q <= 1'b0;
        end else if (in_rdy) begin
          out_vld_q <= bus.in_valid;
          if (bus.in_valid) begin
            val2_q    <= bs_out;
            shift_c_q <= bs_c;
            tag_q     <= bus.in_tag;
          end
        end
      end
    end else begin : g_two
      sh_type_e          s1_sh_q;
      amt_cls_e          s1_cls_q;
      logic [SH_W-1:0]   s1_r_q;
      logic [DATA_W-1:0] s1_opnd_q;
      logic              s1_c_q;
      logic [TAG_W-1:0]  s1_tag_q;
      logic              s1_vld_q;
      logic              s2_rdy;
      logic              s1_adv;
      logic [DATA_W-1:0] bs_out;
      logic              bs_c;

      assign s2_rdy = !out_vld_q | bus.out_ready;
      assign s1_adv = s1_vld_q & s2_rdy;
      assign in_rdy = !s1_vld_q | s1_adv;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_vld_q  <= 1'b0;
          s1_sh_q   <= SH_LSL;
          s1_cls_q  <= AMT_ZERO;
          s1_r_q    <= '0;
          s1_opnd_q <= '0;
          s1_c_q    <= 1'b0;
          s1_tag_q  <= '0;
        end else if (bus.flush) begin
          s1_vld_q <= 1'b0;
        end else if (in_rdy) begin
          s1_vld_q <= bus.in_valid;
          if (bus.in_valid) begin
            s1_sh_q   <= s1_sh_d;
            s1_cls_q  <= s1_cls_d;
            s1_r_q    <= s1_r_d;
            s1_opnd_q <= s1_opnd_d;
            s1_c_q    <= bus.c_in;
            s1_tag_q  <= bus.in_tag;
          end
        end
      end

      barrel_shifter #(.DATA_W(DATA_W), .SH_W(SH_W)) u_bs (
        .in_dat (s1_opnd_q),
        .r      (s1_r_q),
        .sh_type(s1_sh_q),
        .amt_cls(s1_cls_q),
        .c_in   (s1_c_q),
        .out_dat(bs_out),
        .carry  (bs_c)
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_vld_q <= 1'b0;
          val2_q    <= '0;
          shift_c_q <= 1'b0;
          tag_q     <= '0;
        end else if (bus.flush) begin
          out_vld_q <= 1'b0;
        end else if (s2_rdy) begin
          out_vld_q <= s1_vld_q;
          if (s1_vld_q) begin
            val2_q    <= bs_out;
            shift_c_q <= bs_c;
            tag_q     <= s1_tag_q;
          end
        end
      end
    end
  endgenerate

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld_q;
  assign bus.val2      = val2_q;
  assign bus.shift_c   = shift_c_q;
  assign bus.out_tag   = tag_q;

endmodule
